// File: rtl/md_pkg.sv
// Shared definitions for the molecular-dynamics pair generation blocks.
//   DATA_WIDTH      : default float32 coordinate width
//   POS_X/Y/Z       : field index of each coordinate inside a {z,y,x} position word
//   disp_state_t    : pair dispatcher FSM states
//   slice_lsb(k, w) : LSB of slice k in a bus of w-bit slices (lanes or fields)
package md_pkg;

  localparam int DATA_WIDTH = 32;

  // Position word layout: x in the LSBs, then y, then z.
  localparam int POS_X      = 0;
  localparam int POS_Y      = 1;
  localparam int POS_Z      = 2;
  localparam int POS_FIELDS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_REF,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } disp_state_t;

  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rl_pair_lane.sv
// One filter lane of the pair dispatcher. Holds the reference particle
// position and its home-cell index, plus the lane's active flag for the
// current batch, and qualifies the broadcast neighbor into a pair valid.
//   clk, rst        : clock, synchronous active-high reset
//   clr             : drop the active flag (start of a new batch)
//   ld_en / ld_pos  : capture a reference position word {z,y,x}
//   ld_idx          : home-cell index of the captured reference
//   nbr_vld / nbr_j : a neighbor word is on the broadcast bus, with its index
//   same_cell       : home and neighbor cells are the same cell
//   active          : lane holds a reference for this batch
//   pair_vld        : this lane's input_valid bit
//   refx/refy/refz  : reference coordinates
module rl_pair_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    ld_en,
  input  logic [3*DATA_WIDTH-1:0] ld_pos,
  input  logic [ADDR_W-1:0]       ld_idx,
  input  logic                    nbr_vld,
  input  logic [ADDR_W-1:0]       nbr_j,
  input  logic                    same_cell,
  output logic                    active,
  output logic                    pair_vld,
  output logic [DATA_WIDTH-1:0]   refx,
  output logic [DATA_WIDTH-1:0]   refy,
  output logic [DATA_WIDTH-1:0]   refz
);
  import md_pkg::*;

  logic [ADDR_W-1:0] ref_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      ref_idx <= '0;
      refx    <= '0;
      refy    <= '0;
      refz    <= '0;
    end else if (ld_en) begin
      active  <= 1'b1;
      ref_idx <= ld_idx;
      refx    <= ld_pos[slice_lsb(POS_X, DATA_WIDTH) +: DATA_WIDTH];
      refy    <= ld_pos[slice_lsb(POS_Y, DATA_WIDTH) +: DATA_WIDTH];
      refz    <= ld_pos[slice_lsb(POS_Z, DATA_WIDTH) +: DATA_WIDTH];
    end else if (clr) begin
      active  <= 1'b0;
    end
  end

  // Within one cell only pairs with j > i are generated, so each unordered
  // pair appears once and no particle is paired with itself.
  assign pair_vld = active && nbr_vld && (!same_cell || (nbr_j > ref_idx));

endmodule

// File: rtl/rl_pair_dispatcher.sv
// Reference/neighbor pair generator for the range-limited LJ force unit.
// Loads up to NUM_FILTER home particles (one per lane) per batch, then
// streams every neighbor particle past all active lanes.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : job start pulse (ignored while busy)
//   home_count, nbr_count     : particle counts, sampled at start
//   same_cell                 : home and neighbor are the same cell
//   busy, done                : job in progress / completion pulse
//   home_rd_* / nbr_rd_*      : position memory reads, data 1 cycle later
//   input_valid               : per-lane pair valid
//   refx..neighborz           : per-lane coordinate buses, lane k at [k*DW +: DW]
//   back_pressure_to_input    : per-lane almost-full from the force unit
module rl_pair_dispatcher #(
  parameter int DATA_WIDTH          = md_pkg::DATA_WIDTH,
  parameter int NUM_FILTER          = 4,
  parameter int PARTICLE_ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [PARTICLE_ADDR_WIDTH-1:0]   home_count,
  input  logic [PARTICLE_ADDR_WIDTH-1:0]   nbr_count,
  input  logic                             same_cell,
  output logic                             busy,
  output logic                             done,
  output logic                             home_rd_en,
  output logic [PARTICLE_ADDR_WIDTH-1:0]   home_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]          home_rd_data,
  output logic                             nbr_rd_en,
  output logic [PARTICLE_ADDR_WIDTH-1:0]   nbr_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]          nbr_rd_data,
  output logic [NUM_FILTER-1:0]            input_valid,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refx,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refy,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refz,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighborx,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighbory,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighborz,
  input  logic [NUM_FILTER-1:0]            back_pressure_to_input
);
  import md_pkg::*;

  localparam int AW = PARTICLE_ADDR_WIDTH;
  localparam int LW = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

  disp_state_t state;

  logic [AW-1:0]         home_q, nbr_q, base, ld_cnt, j;
  logic [AW-1:0]         rem, batch_len;
  logic                  same_q, stall, lane_clr;
  logic [NUM_FILTER-1:0] lane_act;

  // In-flight read tags: what the word arriving next cycle belongs to.
  logic                  hp_vld, np_vld;
  logic [LW-1:0]         hp_lane;
  logic [AW-1:0]         hp_addr, np_j;
  logic [3*DATA_WIDTH-1:0] nbr_hold, nbr_word;

  always_comb begin
    rem       = home_q - base;
    batch_len = (rem > AW'(NUM_FILTER)) ? AW'(NUM_FILTER) : rem;
  end

  // Back pressure only counts on lanes holding a reference this batch.
  assign stall        = |(back_pressure_to_input & lane_act);
  assign home_rd_en   = (state == ST_LOAD_REF) && (ld_cnt < batch_len);
  assign home_rd_addr = base + ld_cnt;
  assign nbr_rd_en    = (state == ST_STREAM) && !stall;
  assign nbr_rd_addr  = j;
  assign lane_clr     = (state == ST_LOAD_REF) && (ld_cnt == '0);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      home_q <= '0;
      nbr_q  <= '0;
      same_q <= 1'b0;
      base   <= '0;
      ld_cnt <= '0;
      j      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          home_q <= home_count;
          nbr_q  <= nbr_count;
          same_q <= same_cell;
          base   <= '0;
          ld_cnt <= '0;
          j      <= '0;
          state  <= (home_count == '0 || nbr_count == '0) ? ST_DONE : ST_LOAD_REF;
        end
        // ld_cnt runs 0..L: L read cycles, then one cycle for the last
        // word to land in its lane before streaming starts.
        ST_LOAD_REF: begin
          if (ld_cnt == batch_len) begin
            state <= ST_STREAM;
            j     <= '0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        ST_STREAM: if (!stall) begin
          if (j == nbr_q - 1'b1) state <= ST_DRAIN;
          else                   j     <= j + 1'b1;
        end
        ST_DRAIN: begin
          base   <= base + batch_len;
          ld_cnt <= '0;
          state  <= (base + batch_len < home_q) ? ST_LOAD_REF : ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_vld   <= 1'b0;
      hp_lane  <= '0;
      hp_addr  <= '0;
      np_vld   <= 1'b0;
      np_j     <= '0;
      nbr_hold <= '0;
    end else begin
      hp_vld  <= home_rd_en;
      hp_lane <= ld_cnt[LW-1:0];
      hp_addr <= home_rd_addr;
      np_vld  <= nbr_rd_en;
      np_j    <= j;
      if (np_vld) nbr_hold <= nbr_rd_data;
    end
  end

  // Broadcast the neighbor straight from the memory in the cycle it lands,
  // otherwise hold the last broadcast word.
  assign nbr_word = np_vld ? nbr_rd_data : nbr_hold;

  for (genvar k = 0; k < NUM_FILTER; k++) begin : g_lane
    rl_pair_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (AW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (lane_clr),
      .ld_en     (hp_vld && (hp_lane == LW'(k))),
      .ld_pos    (home_rd_data),
      .ld_idx    (hp_addr),
      .nbr_vld   (np_vld),
      .nbr_j     (np_j),
      .same_cell (same_q),
      .active    (lane_act[k]),
      .pair_vld  (input_valid[k]),
      .refx      (refx[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .refy      (refy[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .refz      (refz[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH])
    );

    assign neighborx[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      nbr_word[slice_lsb(POS_X, DATA_WIDTH) +: DATA_WIDTH];
    assign neighbory[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      nbr_word[slice_lsb(POS_Y, DATA_WIDTH) +: DATA_WIDTH];
    assign neighborz[slice_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      nbr_word[slice_lsb(POS_Z, DATA_WIDTH) +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_rl_pair_dispatcher.sv
// Scoreboard bench for rl_pair_dispatcher: a job model builds the ordered
// pair list (batch, then neighbor j, then lane) and the expected done cycle;
// a negedge monitor pops one entry per valid lane and compares coordinates.
module tb_rl_pair_dispatcher;
  localparam int DW = 32;
  localparam int NF = 4;
  localparam int AW = 8;

  typedef struct {
    int               lane;
    logic [3*DW-1:0]  refw;
    logic [3*DW-1:0]  nbrw;
  } pair_t;

  logic clk = 1'b0;
  logic rst, start, same_cell;
  logic [AW-1:0] home_count, nbr_count;
  logic busy, done, home_rd_en, nbr_rd_en;
  logic [AW-1:0] home_rd_addr, nbr_rd_addr;
  logic [3*DW-1:0] home_rd_data = '0, nbr_rd_data = '0;
  logic [NF-1:0] input_valid, bp;
  logic [NF*DW-1:0] refx, refy, refz, neighborx, neighbory, neighborz;

  logic [3*DW-1:0] home_mem [256];
  logic [3*DW-1:0] nbr_mem  [256];

  pair_t exp_q[$];
  pair_t e;
  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  bit mon_en = 0;
  int busy_cnt, hrd_cnt, nrd_cnt, pairs_seen, done_seen, done_cyc;

  rl_pair_dispatcher #(.DATA_WIDTH(DW), .NUM_FILTER(NF), .PARTICLE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .home_count(home_count), .nbr_count(nbr_count),
    .same_cell(same_cell), .busy(busy), .done(done),
    .home_rd_en(home_rd_en), .home_rd_addr(home_rd_addr), .home_rd_data(home_rd_data),
    .nbr_rd_en(nbr_rd_en), .nbr_rd_addr(nbr_rd_addr), .nbr_rd_data(nbr_rd_data),
    .input_valid(input_valid), .refx(refx), .refy(refy), .refz(refz),
    .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
    .back_pressure_to_input(bp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read position memories.
  always @(posedge clk) begin
    if (home_rd_en) home_rd_data <= home_mem[home_rd_addr];
    if (nbr_rd_en)  nbr_rd_data  <= nbr_mem[nbr_rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: one scoreboard pop per valid lane, lowest lane first.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin done_seen++; done_cyc = cyc - start_cyc; end
      if (busy) busy_cnt++;
      if (home_rd_en) hrd_cnt++;
      if (nbr_rd_en) nrd_cnt++;
      for (int k = 0; k < NF; k++) begin
        if (input_valid[k]) begin
          pairs_seen++;
          if (exp_q.size() == 0) begin
            chk("extra_pair_lane", k, 128'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("pair_lane", k, e.lane);
            chk("pair_ref", {refz[k*DW +: DW], refy[k*DW +: DW], refx[k*DW +: DW]}, e.refw);
            chk("pair_nbr", {neighborz[k*DW +: DW], neighbory[k*DW +: DW], neighborx[k*DW +: DW]}, e.nbrw);
          end
        end
      end
    end
  end

  task automatic fill(input bit same);
    for (int i = 0; i < 256; i++) begin
      home_mem[i] = {$urandom, $urandom, $urandom};
      nbr_mem[i]  = same ? home_mem[i] : {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_job(input int h, input int n, input bit same, input int bp_lane,
                         input int bp_from, input int bp_len, input bit bp_chk, input int extra);
    int L, c, exp_done, exp_pairs, batches;
    bit seen;
    exp_q.delete();
    c = 0;
    batches = 0;
    if (h > 0 && n > 0) begin
      for (int b = 0; b < h; b += NF) begin
        L = (h - b < NF) ? h - b : NF;
        c += L + 2 + n;
        batches++;
        for (int jj = 0; jj < n; jj++)
          for (int i = b; i < b + L; i++)
            if (!same || jj > i) exp_q.push_back('{lane: i - b, refw: home_mem[i], nbrw: nbr_mem[jj]});
      end
    end
    exp_done  = c + 1 + extra;
    exp_pairs = (h == 0 || n == 0) ? 0 : (same ? h * (h - 1) / 2 : h * n);
    busy_cnt = 0; hrd_cnt = 0; nrd_cnt = 0; pairs_seen = 0; done_seen = 0; done_cyc = -1;
    mon_en = 1;
    @(posedge clk); #1;
    home_count = AW'(h); nbr_count = AW'(n); same_cell = same; start = 1'b1;
    start_cyc = cyc;
    seen = 0;
    for (int t = 1; t < 3000 && !seen; t++) begin
      @(posedge clk); #1;
      start = (t == 1);  // second start lands while busy (or in the done cycle)
      bp = (bp_len > 0 && t >= bp_from && t < bp_from + bp_len) ? NF'(1 << bp_lane) : '0;
      @(negedge clk);
      if (bp_chk && bp != '0) chk("stall_rd_en", nbr_rd_en, 0);
      if (done) seen = 1;
    end
    if (!seen) chk("timeout_done", 0, 1);
    @(posedge clk); #1;
    start = 1'b0; bp = '0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (2) @(posedge clk);
    mon_en = 0;
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_seen, 1);
    chk("pairs_left", exp_q.size(), 0);
    chk("pair_total", pairs_seen, exp_pairs);
    chk("home_reads", hrd_cnt, (n == 0) ? 0 : h);
    chk("nbr_reads", nrd_cnt, batches * n);
    chk("busy_cycles", busy_cnt, exp_done);
    if (!seen) begin
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    end
  endtask

  task automatic run_reset_mid(input int h, input int n, input int at);
    mon_en = 0;
    @(posedge clk); #1;
    home_count = AW'(h); nbr_count = AW'(n); same_cell = 1'b0; start = 1'b1;
    repeat (at) begin @(posedge clk); #1; start = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", input_valid, 0);
    chk("rst_nbr_rd", nbr_rd_en, 0);
    chk("rst_home_rd", home_rd_en, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    int h, n;
    bit s;
    rst = 1'b1; start = 1'b0; same_cell = 1'b0; home_count = '0; nbr_count = '0; bp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", input_valid, 0);
    chk("reset_rd_en", {home_rd_en, nbr_rd_en}, 0);
    chk("reset_addr", {home_rd_addr, nbr_rd_addr}, 0);
    chk("reset_refx", refx, 0);
    chk("reset_nbrx", neighborx, 0);
    @(posedge clk); #1 rst = 1'b0;

    fill(0); run_job(4, 3, 0, 0, 0, 0, 0, 0);      // done at 10
    fill(0); run_job(6, 2, 0, 3, 11, 4, 0, 0);     // bp on lane 3, inactive in batch 2
    fill(1); run_job(5, 5, 1, 0, 0, 0, 0, 0);      // same cell: 10 pairs
    fill(0); run_job(4, 6, 0, 1, 7, 3, 1, 3);      // 3-cycle stall mid-stream
    run_job(0, 3, 0, 0, 0, 0, 0, 0);
    run_job(3, 0, 0, 0, 0, 0, 0, 0);
    fill(0); run_reset_mid(4, 6, 8);
    run_job(4, 6, 0, 0, 0, 0, 0, 0);               // golden list after reset
    for (int r = 0; r < 6; r++) begin
      s = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 10);
      n = s ? h : $urandom_range(1, 7);
      fill(s);
      run_job(h, n, s, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
